// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - XLEN_DEFAULT : operand/result width (only 32 is supported)
//   - F3_*         : funct3 encodings of the M extension
//   - state_e      : FSM state encoding of muldiv_unit
//   - neg32_if / neg64_if : conditional two's-complement negate, used both to
//     take operand magnitudes and to restore result signs
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic n);
      return n ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] neg64_if(input logic [63:0] v, input logic n);
      return n ? (~v + 64'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               request, sampled only in IDLE
//   flush               synchronous kill of an in-flight operation
//   funct3              M-extension operation select
//   op_a, op_b          rs1 / rs2 values from the register file
//   rd_in               destination register index
//   busy                high in CALC, FIX and DONE (control unit stalls on it)
//   valid               one-cycle result strobe
//   result, rd_out, we  register-file write port (wd3 / wa3 / we3)
//   dbg_state_o         current FSM state, for observation only
//
// Handshake: start is a request with no ready; it is taken only when busy is
// low (IDLE) and flush is low, and operands are captured on that edge only.
// busy then stays high until the cycle after the single valid strobe. There is
// no backpressure on valid: the write port must take the result that cycle.
//
// Datapath: one 64-bit accumulator serves both operations.
//   multiply: acc = {partial product, multiplier}; each step adds the
//             multiplicand into the top half when acc[0] is set, then shifts
//             the whole thing right (the carry goes into bit 63).
//   divide:   acc = {remainder, dividend/quotient}; each step forms the 33-bit
//             partial remainder {rem, next dividend bit}, subtracts the divisor
//             if it fits and shifts the quotient bit into acc[0].
// Both run on magnitudes; signs are restored in FIX.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            we,
   output logic [1:0]      dbg_state_o
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e              state_q, state_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [2:0]          f3_q, f3_d;
   logic [4:0]          rd_q, rd_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic                sa_q, sa_d;       // op_a was negative (signed view)
   logic                sb_q, sb_d;       // op_b was negative (signed view)
   logic [XLEN-1:0]     result_q, result_d;

   // Operand classification at acceptance
   logic            sa_in, sb_in;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf;

   assign sa_in = op_a[XLEN-1] & ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                                  (funct3 == F3_DIV)  || (funct3 == F3_REM));
   assign sb_in = op_b[XLEN-1] & ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                                  (funct3 == F3_REM));
   assign mag_a = neg32_if(op_a, sa_in);
   assign mag_b = neg32_if(op_b, sb_in);

   assign div_zero = funct3[2] && (op_b == '0);
   assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op_a == MIN_NEG) && (op_b == '1);

   // One iteration of each algorithm
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   part_rem;
   logic            rem_ge;
   logic [XLEN-1:0] rem_sub;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
   assign part_rem = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign rem_ge   = (part_rem >= {1'b0, opnd_q});
   // When rem_ge holds the difference is below 2^XLEN, so the low bits suffice.
   assign rem_sub  = part_rem[XLEN-1:0] - opnd_q;

   // Sign restoration and result selection
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   assign prod    = neg64_if(acc_q, sa_q ^ sb_q);
   assign quo_fix = neg32_if(acc_q[XLEN-1:0], sa_q ^ sb_q);
   assign rem_fix = neg32_if(acc_q[2*XLEN-1:XLEN], sa_q);

   always_comb begin
      fix_res = '0;
      case (f3_q)
         F3_MUL:                        fix_res = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:               fix_res = quo_fix;
         default:                       fix_res = rem_fix;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               f3_d  = funct3;
               rd_d  = rd_in;
               sa_d  = sa_in;
               sb_d  = sb_in;
               cnt_d = '0;
               if (funct3[2]) begin
                  opnd_d = mag_b;
                  acc_d  = {{XLEN{1'b0}}, mag_a};
               end else begin
                  opnd_d = mag_a;
                  acc_d  = {{XLEN{1'b0}}, mag_b};
               end
               if (div_zero) begin
                  // REM/REMU (funct3[1]) return the dividend, DIV/DIVU all ones
                  result_d = funct3[1] ? op_a : '1;
                  state_d  = ST_DONE;
               end else if (div_ovf) begin
                  result_d = funct3[1] ? '0 : MIN_NEG;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end

         ST_CALC: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (f3_q[2]) begin
                  acc_d = {(rem_ge ? rem_sub : part_rem[XLEN-1:0]),
                           acc_q[XLEN-2:0], rem_ge};
               end else begin
                  acc_d = {mul_sum, acc_q[XLEN-1:1]};
               end
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(XLEN - 1)) begin
                  state_d = ST_FIX;
               end
            end
         end

         ST_FIX: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               result_d = fix_res;
               state_d  = ST_DONE;
            end
         end

         default: begin
            // DONE lasts exactly one cycle; flush leads to the same place.
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         result_q <= result_d;
      end
   end

   // All outputs are decoded from registers only.
   assign busy        = (state_q != ST_IDLE);
   assign valid       = (state_q == ST_DONE);
   assign result      = result_q;
   assign rd_out      = rd_q;
   assign we          = valid && (rd_q != 5'd0);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, valid, we;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .flush       (flush),
      .funct3      (funct3),
      .op_a        (op_a),
      .op_b        (op_b),
      .rd_in       (rd_in),
      .busy        (busy),
      .valid       (valid),
      .result      (result),
      .rd_out      (rd_out),
      .we          (we),
      .dbg_state_o (dbg_state)
   );

   // ---------------------------------------------------------------- scoreboard
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- driver
   // Presents one request (start sampled at edge E0), then samples 1 ns after
   // every following edge. k counts edges after E0. poke_k re-asserts start
   // with other operands at that sample point; flush_k raises flush there so
   // it is sampled on the next edge.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int poke_k, input int flush_k,
                         output int lat, output int bcyc, output int nvalid,
                         output logic [31:0] res, output logic [4:0] rdo, output logic weo);
      @(negedge clk);
      funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = -1; bcyc = 0; nvalid = 0; res = '0; rdo = '0; weo = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (busy) bcyc++;
         if (valid) begin
            nvalid++;
            if (lat < 0) begin
               lat = k; res = result; rdo = rd_out; weo = we;
            end
         end
         if (k > 0 && !busy) break;
         start = 1'b0;
         flush = 1'b0;
         if (k == poke_k) begin
            start = 1'b1; funct3 = F3_MULHU; op_a = '1; op_b = '1; rd_in = 5'd9;
         end
         if (k == flush_k) flush = 1'b1;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      flush = 1'b0;
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;   // sample index of valid: 33 iterative, 0 special case
   } vec_t;

   localparam int NV = 26;
   vec_t vecs[NV];

   int          lat, bcyc, nvalid, cnt;
   logic [31:0] res;
   logic [4:0]  rdo;
   logic        weo;

   initial begin
      vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
      vecs[1]  = '{F3_MUL,    32'd3,        32'd4,        5'd0,  32'd12,       33};
      vecs[2]  = '{F3_MUL,    32'h12345678, 32'h10,       5'd1,  32'h23456780, 33};
      vecs[3]  = '{F3_MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33};
      vecs[4]  = '{F3_MULH,   32'hFFFFFFFD, 32'd5,        5'd3,  32'hFFFFFFFF, 33};
      vecs[5]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33};
      vecs[6]  = '{F3_MULHU,  32'h00010000, 32'h00010000, 5'd6,  32'h00000001, 33};
      vecs[7]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 33};
      vecs[8]  = '{F3_MULHSU, 32'd2,        32'h80000000, 5'd8,  32'h00000001, 33};
      vecs[9]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33};
      vecs[10] = '{F3_REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33};
      vecs[11] = '{F3_DIVU,   32'd7,        32'd2,        5'd11, 32'd3,        33};
      vecs[12] = '{F3_REMU,   32'hFFFFFFFF, 32'd16,       5'd12, 32'd15,       33};
      vecs[13] = '{F3_DIV,    32'd100,      32'hFFFFFFF9, 5'd13, 32'hFFFFFFF2, 33};
      vecs[14] = '{F3_REM,    32'd100,      32'hFFFFFFF9, 5'd14, 32'd2,        33};
      vecs[15] = '{F3_DIV,    32'h80000000, 32'd2,        5'd15, 32'hC0000000, 33};
      vecs[16] = '{F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        33};
      vecs[17] = '{F3_REMU,   32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 33};
      vecs[18] = '{F3_DIVU,   32'hFFFFFFFF, 32'd3,        5'd18, 32'h55555555, 33};
      vecs[19] = '{F3_REM,    32'h80000000, 32'd3,        5'd19, 32'hFFFFFFFE, 33};
      vecs[20] = '{F3_DIV,    32'd5,        32'd0,        5'd20, 32'hFFFFFFFF, 0};
      vecs[21] = '{F3_REM,    32'd5,        32'd0,        5'd21, 32'd5,        0};
      vecs[22] = '{F3_DIVU,   32'd5,        32'd0,        5'd22, 32'hFFFFFFFF, 0};
      vecs[23] = '{F3_REMU,   32'd5,        32'd0,        5'd23, 32'd5,        0};
      vecs[24] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd24, 32'h80000000, 0};
      vecs[25] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd25, 32'd0,        0};

      // Reset values while rst is held low
      #2;
      check("reset busy",   32'(busy),      32'd0);
      check("reset valid",  32'(valid),     32'd0);
      check("reset result", result,         32'd0);
      check("reset rd_out", 32'(rd_out),    32'd0);
      check("reset we",     32'(we),        32'd0);
      check("reset state",  32'(dbg_state), 32'(ST_IDLE));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Table: each request starts in the first IDLE cycle after the previous one
      for (int i = 0; i < NV; i++) begin
         exp_q.push_back(vecs[i].exp);
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, -1, -1,
                lat, bcyc, nvalid, res, rdo, weo);
         check($sformatf("v%0d result", i),  res, exp_q.pop_front());
         check($sformatf("v%0d rd_out", i),  32'(rdo), 32'(vecs[i].rd));
         check($sformatf("v%0d we", i),      32'(weo), 32'(vecs[i].rd != 5'd0));
         check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d nvalid", i),  32'(nvalid), 32'd1);
         check($sformatf("v%0d busy cycles", i), 32'(bcyc), 32'(vecs[i].lat + 1));
      end

      // start pulsed while busy must not disturb the running multiply
      exp_q.push_back(32'hFFFFFFEB);
      run_op(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 5, -1, lat, bcyc, nvalid, res, rdo, weo);
      check("busy-start result",  res, exp_q.pop_front());
      check("busy-start rd_out",  32'(rdo), 32'd5);
      check("busy-start latency", 32'(lat), 32'd33);
      check("busy-start nvalid",  32'(nvalid), 32'd1);
      check("busy-start bcyc",    32'(bcyc), 32'd34);

      // flush sampled at E10: busy for 10 cycles, IDLE right after, no strobe
      run_op(F3_DIV, 32'd1000, 32'd7, 5'd3, -1, 9, lat, bcyc, nvalid, res, rdo, weo);
      check("flush nvalid", 32'(nvalid), 32'd0);
      check("flush bcyc",   32'(bcyc), 32'd10);
      check("flush state",  32'(dbg_state), 32'(ST_IDLE));
      cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid) cnt++;
      end
      check("flush late valid", 32'(cnt), 32'd0);
      check("flush keeps result", result, 32'hFFFFFFEB);

      // flush beats start in IDLE
      @(negedge clk);
      funct3 = F3_MUL; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1;
      start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      check("flush over start busy", 32'(busy), 32'd0);

      // Reset in the middle of an operation
      @(negedge clk);
      funct3 = F3_MULHU; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; rd_in = 5'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("pre-reset busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("mid reset busy",   32'(busy),      32'd0);
      check("mid reset valid",  32'(valid),     32'd0);
      check("mid reset result", result,         32'd0);
      check("mid reset rd_out", 32'(rd_out),    32'd0);
      check("mid reset we",     32'(we),        32'd0);
      check("mid reset state",  32'(dbg_state), 32'(ST_IDLE));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Recovery after reset, write to x0 suppressed
      exp_q.push_back(32'd12);
      run_op(F3_MUL, 32'd3, 32'd4, 5'd0, -1, -1, lat, bcyc, nvalid, res, rdo, weo);
      check("post-reset result",  res, exp_q.pop_front());
      check("post-reset we",      32'(weo), 32'd0);
      check("post-reset latency", 32'(lat), 32'd33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
